// File: rtl/id_stage_pipe.sv
// ARM-style decode stage: register file with write-through bypass, condition check,
// RAW hazard detection and the ID/EX pipeline register with freeze/flush.
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 4,
    parameter int CTRL_W   = 9,
    parameter int MEMR_BIT = 7,
    parameter int MEMW_BIT = 6,
    parameter int FWD_EN   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] pc,
    input  logic [31:0]       instruction,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              two_src,
    input  logic [3:0]        flags_in,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              freeze,
    input  logic              flush,
    output logic              hazard,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_val_rn,
    output logic [DATA_W-1:0] ex_val_rm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_imm,
    output logic [11:0]       ex_shift_op,
    output logic [23:0]       ex_simm,
    output logic [REG_AW-1:0] ex_dest,
    output logic [REG_AW-1:0] ex_src1,
    output logic [REG_AW-1:0] ex_src2,
    output logic [3:0]        ex_flags
);

    localparam int NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREGS];
    logic [REG_AW-1:0] src1, src2;
    logic [DATA_W-1:0] val_rn, val_rm;
    logic              cond_ok;
    logic              hz_full, hz_load_use;
    logic              unused;

    // Opcode/S bits are decoded by the external control unit, not here.
    assign unused = ^{instruction[27:26], instruction[24]};

    // Stores read Rd as their second source (the data to be stored).
    assign src1 = instruction[16 +: REG_AW];
    assign src2 = ctrl_in[MEMW_BIT] ? instruction[12 +: REG_AW] : instruction[0 +: REG_AW];

    assign val_rn = (wb_en && wb_dest == src1) ? wb_value : regs[src1];
    assign val_rm = (wb_en && wb_dest == src2) ? wb_value : regs[src2];

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return c;
            4'b0011: return !c;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return c && !z;
            4'b1001: return !c || z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return z || (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign cond_ok = cond_pass(instruction[31:28], flags_in);

    always_comb begin
        hz_full = (exe_wb_en && exe_dest == src1) || (mem_wb_en && mem_dest == src1) ||
                  (two_src && ((exe_wb_en && exe_dest == src2) || (mem_wb_en && mem_dest == src2)));
        hz_load_use = exe_mem_read && exe_wb_en &&
                      (exe_dest == src1 || (two_src && exe_dest == src2));
        hazard = instr_valid && ((FWD_EN != 0) ? hz_load_use : hz_full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_dest] <= wb_value;
        end
    end

    // ID/EX boundary: flush beats freeze; bubbles only clear valid and ctrl.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_val_rn   <= '0;
            ex_val_rm   <= '0;
            ex_ctrl     <= '0;
            ex_imm      <= 1'b0;
            ex_shift_op <= '0;
            ex_simm     <= '0;
            ex_dest     <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_flags    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (!freeze) begin
            if (hazard || !instr_valid) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
            end else begin
                ex_valid    <= 1'b1;
                ex_pc       <= pc;
                ex_val_rn   <= val_rn;
                ex_val_rm   <= val_rm;
                ex_ctrl     <= cond_ok ? ctrl_in : '0;
                ex_imm      <= instruction[25];
                ex_shift_op <= instruction[11:0];
                ex_simm     <= instruction[23:0];
                ex_dest     <= instruction[12 +: REG_AW];
                ex_src1     <= src1;
                ex_src2     <= src2;
                ex_flags    <= flags_in;
            end
        end
    end

endmodule
